// File: rtl/tcdm_axi_lite_master.sv
// TCDM slave to AXI4-Lite master bridge, one outstanding access; grant only in IDLE, 3-cycle minimum response.
// AXI valids hold until their handshake; TCDM side is stalled by withholding grant while busy.
module tcdm_axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    tcdm_req_i,
  output logic                    tcdm_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
  input  logic                    tcdm_wen_i,
  input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
  output logic                    tcdm_r_valid_o,
  output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
  output logic                    tcdm_r_opc_o,

  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr_o,
  output logic [2:0]              axi_awprot_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  output logic [DATA_WIDTH-1:0]   axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb_o,
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o,
  input  logic [1:0]              axi_bresp_i,
  output logic                    axi_arvalid_o,
  input  logic                    axi_arready_i,
  output logic [ADDR_WIDTH-1:0]   axi_araddr_o,
  output logic [2:0]              axi_arprot_o,
  input  logic                    axi_rvalid_i,
  output logic                    axi_rready_o,
  input  logic [DATA_WIDTH-1:0]   axi_rdata_i,
  input  logic [1:0]              axi_rresp_i,

  output logic [CNT_WIDTH-1:0]    rd_cnt_o,
  output logic [CNT_WIDTH-1:0]    wr_cnt_o,
  output logic [CNT_WIDTH-1:0]    err_cnt_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_D,
    S_WR_AW_W,
    S_WR_B,
    S_RSP
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_add;
  logic                  r_wen;
  logic [BE_WIDTH-1:0]   r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_resp;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_bready;
  logic                  r_rvalid;
  logic [CNT_WIDTH-1:0]  r_rd_cnt;
  logic [CNT_WIDTH-1:0]  r_wr_cnt;
  logic [CNT_WIDTH-1:0]  r_err_cnt;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_aw_ok;
  logic                  w_w_ok;
  logic                  w_rd_err;
  logic                  w_wr_err;
  logic [CNT_WIDTH-1:0]  w_err_cnt_inc;

  assign w_aw_hs       = r_awvalid & axi_awready_i;
  assign w_w_hs        = r_wvalid & axi_wready_i;
  assign w_aw_ok       = r_aw_done | w_aw_hs;
  assign w_w_ok        = r_w_done | w_w_hs;
  assign w_rd_err      = (axi_rresp_i != 2'b00);
  assign w_wr_err      = (axi_bresp_i != 2'b00);
  assign w_err_cnt_inc = (r_err_cnt == {CNT_WIDTH{1'b1}}) ? r_err_cnt : r_err_cnt + 1'b1;

  assign tcdm_gnt_o     = tcdm_req_i & (r_state == S_IDLE);
  assign tcdm_r_valid_o = r_rvalid;
  // Response payload is forced to zero whenever no response is being presented.
  assign tcdm_r_data_o  = (r_rvalid & r_wen) ? r_rdata : '0;
  assign tcdm_r_opc_o   = r_rvalid & (r_resp != 2'b00);

  assign axi_awvalid_o = r_awvalid;
  assign axi_awaddr_o  = r_add;
  assign axi_awprot_o  = 3'b000;
  assign axi_wvalid_o  = r_wvalid;
  assign axi_wdata_o   = r_wdata;
  assign axi_wstrb_o   = r_be;
  assign axi_bready_o  = r_bready;
  assign axi_arvalid_o = r_arvalid;
  assign axi_araddr_o  = r_add;
  assign axi_arprot_o  = 3'b000;
  assign axi_rready_o  = r_rready;

  assign rd_cnt_o  = r_rd_cnt;
  assign wr_cnt_o  = r_wr_cnt;
  assign err_cnt_o = r_err_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_add     <= '0;
      r_wen     <= 1'b0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_resp    <= 2'b00;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_bready  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tcdm_req_i) begin
            r_add   <= tcdm_add_i;
            r_wen   <= tcdm_wen_i;
            r_be    <= tcdm_be_i;
            r_wdata <= tcdm_data_i;
            r_rdata <= '0;
            r_resp  <= 2'b00;
            if (tcdm_wen_i) begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_A;
            end else begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= S_WR_AW_W;
            end
          end
        end
        S_RD_A: begin
          if (axi_arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_D;
          end
        end
        S_RD_D: begin
          if (axi_rvalid_i) begin
            r_rready <= 1'b0;
            r_rdata  <= axi_rdata_i;
            r_resp   <= axi_rresp_i;
            r_rvalid <= 1'b1;
            r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_rd_err) r_err_cnt <= w_err_cnt_inc;
            r_state  <= S_RSP;
          end
        end
        S_WR_AW_W: begin
          // Address and data channels retire independently; B is only awaited once both are done.
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_ok && w_w_ok) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (axi_bvalid_i) begin
            r_bready <= 1'b0;
            r_resp   <= axi_bresp_i;
            r_rvalid <= 1'b1;
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_wr_err) r_err_cnt <= w_err_cnt_inc;
            r_state  <= S_RSP;
          end
        end
        S_RSP: begin
          r_rvalid <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_rvalid  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcdm_axi_lite_master.sv
// Directed bench for tcdm_axi_lite_master: vector table of single transactions plus back-to-back, reset and saturation sequences.
module tb_tcdm_axi_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, gnt, wen, r_valid, r_opc;
  logic [AW-1:0] add;
  logic [3:0]    be;
  logic [DW-1:0] data, r_data;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [CW-1:0] rd_cnt, wr_cnt, err_cnt;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] exp_rd = '0;
  logic [CW-1:0] exp_wr = '0;
  logic [CW-1:0] exp_err = '0;

  always #5 clk = ~clk;

  tcdm_axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(data),
    .tcdm_r_valid_o(r_valid), .tcdm_r_data_o(r_data), .tcdm_r_opc_o(r_opc),
    .axi_awvalid_o(awvalid), .axi_awready_i(awready), .axi_awaddr_o(awaddr), .axi_awprot_o(awprot),
    .axi_wvalid_o(wvalid), .axi_wready_i(wready), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb),
    .axi_bvalid_i(bvalid), .axi_bready_o(bready), .axi_bresp_i(bresp),
    .axi_arvalid_o(arvalid), .axi_arready_i(arready), .axi_araddr_o(araddr), .axi_arprot_o(arprot),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready), .axi_rdata_i(rdata), .axi_rresp_i(rresp),
    .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .err_cnt_o(err_cnt)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    int          rb_dly;
    logic [31:0] exp_data;
    logic        exp_opc;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called with clk low; returns at the negedge after the response cycle with the DUT idle.
  task automatic do_txn(input vec_t v, input bit hold_req);
    int          lat = 0;
    int          ar_n = 0, aw_n = 0, w_n = 0, rb_n = 0, ar_stall = 0;
    bit          aw_first = 0, w_first = 0;
    logic        p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
    logic [31:0] got_addr = '0, got_wdata = '0, got_data = '0;
    logic [3:0]  got_wstrb = '0;
    logic        got_opc = 1'b0;
    logic [CW-1:0] got_rd = '0, got_wr = '0, got_err = '0;

    req = 1'b1; wen = v.wen; add = v.addr; be = v.be; data = v.data;
    arready = (v.ar_dly == 0); awready = (v.aw_dly == 0); wready = (v.w_dly == 0);
    rvalid = (v.rb_dly == 0); bvalid = (v.rb_dly == 0);
    rdata = v.rdata; rresp = v.resp; bresp = v.resp;
    #1 chk("gnt", gnt, 1);
    @(posedge clk);
    if (v.wen) exp_rd = exp_rd + 1'b1;
    else       exp_wr = exp_wr + 1'b1;
    if (v.resp != 2'b00 && exp_err != {CW{1'b1}}) exp_err = exp_err + 1'b1;

    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (!hold_req) req = 1'b0;
      if (hold_req) chk("gnt_busy", gnt, 0);
      if (p_arv && !p_arr) chk("arvalid_hold", arvalid, 1);
      if (p_awv && !p_awr) chk("awvalid_hold", awvalid, 1);
      if (p_wv && !p_wr)   chk("wvalid_hold", wvalid, 1);
      if (arvalid) got_addr = araddr;
      if (awvalid) got_addr = awaddr;
      if (wvalid) begin got_wdata = wdata; got_wstrb = wstrb; end
      if (!awvalid && wvalid) aw_first = 1;
      if (awvalid && !wvalid) w_first = 1;
      if (r_valid) begin
        lat = cyc; got_data = r_data; got_opc = r_opc;
        got_rd = rd_cnt; got_wr = wr_cnt; got_err = err_cnt;
        break;
      end
      arready = arvalid ? (ar_n >= v.ar_dly) : (v.ar_dly == 0);
      if (arvalid) begin if (!arready) ar_stall++; ar_n++; end
      awready = awvalid ? (aw_n >= v.aw_dly) : (v.aw_dly == 0);
      if (awvalid) aw_n++;
      wready = wvalid ? (w_n >= v.w_dly) : (v.w_dly == 0);
      if (wvalid) w_n++;
      if (v.rb_dly != 0) begin
        rvalid = rready && (rb_n >= v.rb_dly);
        bvalid = bready && (rb_n >= v.rb_dly);
        if (rready || bready) rb_n++;
      end
      p_arv = arvalid; p_arr = arready;
      p_awv = awvalid; p_awr = awready;
      p_wv  = wvalid;  p_wr  = wready;
    end

    chk("latency", lat, v.exp_lat);
    chk("r_data", got_data, v.exp_data);
    chk("r_opc", got_opc, v.exp_opc);
    chk("rd_cnt", got_rd, exp_rd);
    chk("wr_cnt", got_wr, exp_wr);
    chk("err_cnt", got_err, exp_err);
    if (v.wen) begin
      chk("araddr", got_addr, v.addr);
      chk("ar_stall", ar_stall, v.ar_dly);
    end else begin
      chk("awaddr", got_addr, v.addr);
      chk("wdata", got_wdata, v.data);
      chk("wstrb", got_wstrb, v.be);
      if (v.w_dly > v.aw_dly) chk("aw_first", aw_first, 1);
      if (v.aw_dly > v.w_dly) chk("w_first", w_first, 1);
    end
    @(negedge clk);
    chk("rvalid_1cyc", r_valid, 0);
    chk("r_data_idle", r_data, 0);
    chk("r_opc_idle", r_opc, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t b1, b2, rv, sv;
    //          wen   addr          data          be       rdata         resp   ar aw w rb exp_data      opc lat
    vecs[0] = '{1'b1, 32'h0000_1000, 32'h0,        4'hF,    32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h0000_2004, 32'hA5A5_A5A5, 4'b0011, 32'h0,        2'b00, 0, 0, 2, 0, 32'h0,        1'b0, 5};
    vecs[2] = '{1'b1, 32'h0000_3000, 32'h0,        4'hF,    32'h1234_5678, 2'b10, 0, 0, 0, 0, 32'h1234_5678, 1'b1, 3};
    vecs[3] = '{1'b0, 32'h0000_0040, 32'h1122_3344, 4'hF,    32'h0,        2'b11, 0, 0, 0, 3, 32'h0,        1'b1, 6};
    vecs[4] = '{1'b0, 32'h0000_0044, 32'h5566_7788, 4'b1000, 32'h0,        2'b00, 0, 3, 0, 0, 32'h0,        1'b0, 6};
    vecs[5] = '{1'b1, 32'h0000_0008, 32'h0,        4'hF,    32'hCAFE_F00D, 2'b01, 0, 0, 0, 2, 32'hCAFE_F00D, 1'b1, 5};
    vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'h0,        4'hF,    32'hFFFF_FFFF, 2'b00, 1, 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 4};
    b1 = '{1'b1, 32'h0000_0100, 32'h0, 4'hF, 32'h0101_0101, 2'b00, 5, 0, 0, 0, 32'h0101_0101, 1'b0, 8};
    b2 = '{1'b1, 32'h0000_0104, 32'h0, 4'hF, 32'h0202_0202, 2'b00, 0, 0, 0, 0, 32'h0202_0202, 1'b0, 3};
    rv = '{1'b1, 32'h0000_0200, 32'h0, 4'hF, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 0, 32'h0BAD_F00D, 1'b0, 3};
    sv = '{1'b1, 32'h0000_0300, 32'h0, 4'hF, 32'h5A5A_5A5A, 2'b10, 0, 0, 0, 0, 32'h5A5A_5A5A, 1'b1, 3};

    rst = 1'b1; req = 1'b0; wen = 1'b0; add = '0; be = '0; data = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_ropc", r_opc, 0);
    chk("rst_cnts", {rd_cnt, wr_cnt, err_cnt}, 0);
    chk("rst_prot", {awprot, arprot}, 0);

    rst = 1'b0;
    foreach (vecs[i]) do_txn(vecs[i], 1'b0);

    do_txn(b1, 1'b1);
    do_txn(b2, 1'b0);

    // Reset while waiting for a write response: the write must vanish without a TCDM response.
    req = 1'b1; wen = 1'b0; add = 32'h50; data = 32'h77; be = 4'hF;
    awready = 1'b1; wready = 1'b1; arready = 1'b1; bvalid = 1'b0; rvalid = 1'b0;
    #1 chk("mid_gnt", gnt, 1);
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    chk("mid_bready", bready, 1);
    rst = 1'b1;
    #1;
    chk("mid_bready_async", bready, 0);
    chk("mid_rvalid", r_valid, 0);
    chk("mid_cnts", {rd_cnt, wr_cnt, err_cnt}, 0);
    exp_rd = '0; exp_wr = '0; exp_err = '0;
    bvalid = 1'b1;
    @(negedge clk);
    chk("mid_rvalid_rst", r_valid, 0);
    rst = 1'b0;
    do_txn(rv, 1'b0);

    for (int k = 0; k < 18; k++) do_txn(sv, 1'b0);
    chk("err_sat", err_cnt, 15);
    chk("rd_wrap", rd_cnt, 4'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tcdm_axi_lite_master.md
TCDM_AXI_LITE_MASTER -- requirements
Module: tcdm_axi_lite_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning TCDM/AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width; byte enables are DATA_WIDTH/8 wide.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning width of the statistics counters.
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk_i in 1 (all logic on rising edge), rst_i in 1 (async assert, active high).
REQ-005 SHALL have TCDM slave ports:
- tcdm_req_i in 1
- tcdm_gnt_o out 1
- tcdm_add_i in ADDR_WIDTH
- tcdm_wen_i in 1 (1=read, 0=write)
- tcdm_be_i in DATA_WIDTH/8
- tcdm_data_i in DATA_WIDTH
- tcdm_r_valid_o out 1
- tcdm_r_data_o out DATA_WIDTH
- tcdm_r_opc_o out 1 (1=error)
REQ-006 SHALL have AXI4-Lite master ports (all standard directions, widths per parameters, prot fixed 3'b000):
- awvalid/awready/awaddr/awprot
- wvalid/wready/wdata/wstrb
- bvalid/bready/bresp[1:0]
- arvalid/arready/araddr/arprot
- rvalid/rready/rdata/rresp[1:0]
All AXI port names are prefixed axi_ with _o/_i suffixes; this AXI master drives the bridge subordinate consumed by the Renode memory stage.
REQ-007 SHALL have outputs rd_cnt_o, wr_cnt_o, err_cnt_o, each CNT_WIDTH wide: completed reads, completed writes, and error responses.

Function
REQ-008 SHALL implement FSM states IDLE, RD_A, RD_D, WR_AW_W, WR_B, RSP; one outstanding transaction only.
REQ-009 SHALL drive tcdm_gnt_o = tcdm_req_i AND (state==IDLE), combinationally; no grant in any other state.
REQ-010 SHALL, on req&gnt, latch add/wen/be/data and go to RD_A if wen=1, else WR_AW_W.
REQ-011 SHALL in RD_A drive axi_arvalid_o=1, araddr=latched address; on arready go to RD_D; arvalid SHALL hold until accepted.
REQ-012 SHALL in RD_D drive axi_rready_o=1; on rvalid latch rdata and rresp and go to RSP.
REQ-013 SHALL on entering WR_AW_W assert awvalid and wvalid together (wdata=latched data, wstrb=latched be). Each valid deasserts independently after its own handshake; the state goes to WR_B the cycle after both have completed, including when both complete in the same cycle.
REQ-014 SHALL in WR_B drive axi_bready_o=1; on bvalid latch bresp and go to RSP.
REQ-015 SHALL in RSP assert tcdm_r_valid_o for exactly one cycle, then return to IDLE.
- tcdm_r_data_o = latched rdata for reads, 0 for writes.
- tcdm_r_opc_o = (latched resp != 2'b00).
REQ-016 SHALL keep tcdm_r_data_o/tcdm_r_opc_o stable only while r_valid=1; outside that they are 0.
REQ-017 SHALL give a minimum latency, with all readies high, of 3 cycles from the grant edge to tcdm_r_valid_o for both reads and writes.
REQ-018 SHALL increment rd_cnt_o/wr_cnt_o in the RSP cycle, wrapping modulo 2^CNT_WIDTH.
REQ-019 SHALL increment err_cnt_o in the RSP cycle when the response is non-OKAY, saturating at all-ones; error transactions also count in rd_cnt_o/wr_cnt_o.
REQ-020 SHALL not depend on AXI ready being asserted before valid, and SHALL never deassert a valid before its handshake.

Reset
REQ-021 SHALL on rst_i=1 immediately (asynchronously) force state IDLE, all AXI valids/readies 0, tcdm_r_valid_o/r_data/r_opc 0, counters 0, latched registers 0.
REQ-022 SHALL abandon any in-flight transaction on reset mid-operation, with no TCDM response issued for it.
REQ-023 SHALL assert tcdm_gnt_o in the first cycle after reset release if tcdm_req_i=1.

Verification
REQ-024 SHALL verify a read with add=0x1000 and readies tied high, memory returning 0xDEADBEEF: a single grant, araddr=0x1000, r_valid 3 cycles later with r_data=0xDEADBEEF, r_opc=0, rd_cnt=1.
REQ-025 SHALL verify a write with add=0x2004, data=0xA5A5A5A5, be=4'b0011, where awready comes 2 cycles before wready: awvalid drops first, wstrb=0011, r_valid has r_data=0, wr_cnt=1.
REQ-026 SHALL verify a read that gets rresp=2'b10: r_opc=1, err_cnt=1, rd_cnt=1.
REQ-027 SHALL verify back-to-back reqs held high: gnt is low from the grant cycle+1 through RSP and the second grant occurs the cycle after RSP; arvalid stays high across 5 stalled arready cycles.
REQ-028 SHALL verify rst_i pulsed during WR_B: bready drops asynchronously, no r_valid is issued, counters are 0, and a new request is granted after release.
REQ-029 SHALL verify err_cnt preset near saturation via 2^CNT_WIDTH error responses (with CNT_WIDTH=4): err_cnt holds at 15.
